coherence_mem_responder: RTL and testbench



---
 rtl/coherence_mem_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_coherence_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_mem_responder.sv
// Memory-side last-resort line supplier on the coherence request/response buses.
// Optional feature: define COH_MEM_SNOOP_CANCEL_EN to cancel a queued read when a cache supplies the line.
package coherence_pkg;

  typedef enum logic [1:0] {
    REQ_READ      = 2'd0,
    REQ_UPGRADE   = 2'd1,
    REQ_WRITEBACK = 2'd2,
    REQ_EVICT     = 2'd3
  } req_kind_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  src;
    req_kind_t   kind;
  } req_msg_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [3:0]   dst;
    logic [3:0]   src;
  } resp_msg_t;

endpackage

module coherence_mem_responder
  import coherence_pkg::*;
#(
  parameter int ID        = 15,
  parameter int QDEPTH    = 4,
  parameter int SNOOP_WIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  req_msg_t     req_bus_msg,
  input  resp_msg_t    resp_bus_msg,
  output resp_msg_t    resp_bus_tx,
  output logic         resp_bus_req,
  input  logic         resp_bus_gnt,
  output logic         resp_bus_busy,
  output logic         req_bus_busy,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SNOOP_WIN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_MEM   = 3'd2,
    S_ARB   = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  logic [26:0]   q_addr_r [QDEPTH];
  logic [3:0]    q_src_r  [QDEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic [26:0]   head_addr_s;
  logic [3:0]    head_src_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [SW-1:0] snoop_cnt_r;
  logic [SW-1:0] snoop_cnt_next_s;
  logic          cancel_s;
  logic          line_load_s;
  logic [255:0]  line_r;
  logic          unused_s;

  assign push_s      = req_bus_msg.valid && (req_bus_msg.kind == REQ_READ);
  assign full_s      = (count_r == CW'(QDEPTH));
  // When full, a push only lands if the head leaves in the same cycle.
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign head_addr_s = q_addr_r[rd_ptr_r];
  assign head_src_s  = q_src_r[rd_ptr_r];
  assign unused_s    = ^{req_bus_msg.addr[4:0], resp_bus_msg};

`ifdef COH_MEM_SNOOP_CANCEL_EN
  assign cancel_s = (state_r == S_SNOOP) && resp_bus_msg.valid &&
                    (resp_bus_msg.addr[31:5] == head_addr_s);
`else
  assign cancel_s = 1'b0;
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    if (wr_en_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !wr_en_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Request queue storage, pointers and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        q_addr_r[wr_ptr_r] <= req_bus_msg.addr[31:5];
        q_src_r[wr_ptr_r]  <= req_bus_msg.src;
        wr_ptr_r           <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Next-state logic; IDLE also reacts to a same-cycle push so SNOOP starts the cycle after capture.
  always_comb begin
    state_next_s     = state_r;
    snoop_cnt_next_s = snoop_cnt_r;
    pop_s            = 1'b0;
    line_load_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if ((count_r != CW'(0)) || push_s) begin
          state_next_s     = S_SNOOP;
          snoop_cnt_next_s = SW'(SNOOP_WIN);
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_SNOOP: begin
        if (cancel_s) begin
          pop_s        = 1'b1;
          state_next_s = S_IDLE;
        end else if (snoop_cnt_r <= SW'(1)) begin
          snoop_cnt_next_s = '0;
          state_next_s     = S_MEM;
        end else begin
          snoop_cnt_next_s = snoop_cnt_r - SW'(1);
        end
      end
      S_MEM: begin
        if (mem_resp) begin
          line_load_s  = 1'b1;
          state_next_s = S_ARB;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_ARB: begin
        if (resp_bus_gnt) begin
          state_next_s = S_SEND;
        end else begin
          state_next_s = S_ARB;
        end
      end
      S_SEND: begin
        pop_s        = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, snoop counter and line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      snoop_cnt_r <= '0;
      line_r      <= '0;
    end else begin
      state_r     <= state_next_s;
      snoop_cnt_r <= snoop_cnt_next_s;
      if (line_load_s) begin
        line_r <= mem_rdata;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read      <= 1'b0;
      mem_addr      <= 32'h0000_0000;
      resp_bus_req  <= 1'b0;
      resp_bus_busy <= 1'b0;
      req_bus_busy  <= 1'b0;
      resp_bus_tx   <= '0;
    end else begin
      mem_read      <= (state_next_s == S_MEM);
      mem_addr      <= (state_next_s == S_MEM) ? {head_addr_s, 5'b00000} : 32'h0000_0000;
      resp_bus_req  <= (state_next_s == S_ARB);
      resp_bus_busy <= (state_next_s == S_SEND);
      req_bus_busy  <= (count_next_s >= CW'(QDEPTH - 1));
      if (state_next_s == S_SEND) begin
        resp_bus_tx <= '{valid: 1'b1, addr: {head_addr_s, 5'b00000}, data: line_r,
                         dst: head_src_s, src: 4'(ID)};
      end else begin
        resp_bus_tx <= '0;
      end
    end
  end

  coherence_mem_responder_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .overflow (overflow_r)
  );

endmodule

// Simulation-only checks for coherence_mem_responder.
module coherence_mem_responder_chk (
  input logic clk,
  input logic rst,
  input logic overflow
);

  // A dropped request means a sender ignored the request-bus stall.
  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !overflow);

endmodule

// File: tb/tb_coherence_mem_responder.sv
// Directed bench for coherence_mem_responder with a latency-programmable memory and arbiter model.
module tb_coherence_mem_responder;
  import coherence_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  req_msg_t     req_bus_msg;
  resp_msg_t    resp_bus_msg;
  resp_msg_t    resp_bus_tx;
  logic         resp_bus_req;
  logic         resp_bus_gnt;
  logic         resp_bus_busy;
  logic         req_bus_busy;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int mem_lat = 3;
  int gnt_delay = 0;
  int mem_cnt = 0;
  int req_cnt = 0;
  int nogrant_cycles = 0;
  int busy_first = -1;
  int tx_leak = 0;
  int mem_unstable = 0;
  logic [31:0] prev_mem_addr = 32'h0;
  resp_msg_t   send_q[$];
  int          send_cyc_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_cyc_q[$];

  always #5 clk = ~clk;

  coherence_mem_responder #(.ID(15), .QDEPTH(4), .SNOOP_WIN(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_bus_msg   (req_bus_msg),
    .resp_bus_msg  (resp_bus_msg),
    .resp_bus_tx   (resp_bus_tx),
    .resp_bus_req  (resp_bus_req),
    .resp_bus_gnt  (resp_bus_gnt),
    .resp_bus_busy (resp_bus_busy),
    .req_bus_busy  (req_bus_busy),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp)
  );

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'hDEAD_BEEF, 32'h1234_5678, a + 32'd7, 32'h0000_0000, ~a, a ^ 32'h0F0F_0F0F};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    send_q.delete();
    send_cyc_q.delete();
    mem_addr_q.delete();
    mem_cyc_q.delete();
    nogrant_cycles = 0;
    busy_first = -1;
  endtask

  // Advance one cycle, observe outputs #1 after the edge and update the memory/arbiter models.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (resp_bus_tx.valid) begin
      send_q.push_back(resp_bus_tx);
      send_cyc_q.push_back(cyc);
    end else if (resp_bus_tx !== '0) begin
      tx_leak++;
    end
    if (req_bus_busy && busy_first < 0) busy_first = cyc;
    if (mem_read) begin
      if (mem_cnt == 0) begin
        mem_addr_q.push_back(mem_addr);
        mem_cyc_q.push_back(cyc);
      end else if (mem_addr !== prev_mem_addr) begin
        mem_unstable++;
      end
      prev_mem_addr = mem_addr;
      mem_cnt++;
      mem_resp  = (mem_cnt == mem_lat);
      mem_rdata = mem_resp ? line_of(mem_addr) : '0;
    end else begin
      mem_cnt   = 0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
    end
    if (resp_bus_req) begin
      req_cnt++;
      resp_bus_gnt = (req_cnt > gnt_delay);
      if (!resp_bus_gnt) nogrant_cycles++;
    end else begin
      req_cnt      = 0;
      resp_bus_gnt = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_req(input logic [31:0] a, input logic [3:0] s, input req_kind_t k);
    req_bus_msg = '{valid: 1'b1, addr: a, src: s, kind: k};
    step();
    req_bus_msg = '0;
  endtask

  initial begin
    int c0;
    rst          = 1'b1;
    req_bus_msg  = '0;
    resp_bus_msg = '0;
    resp_bus_gnt = 1'b0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    run(2);
    rst = 1'b0;
    check("reset_outputs", {resp_bus_tx, resp_bus_req, resp_bus_busy, req_bus_busy, mem_addr, mem_read}, '0);
    check("reset_fifo_empty", dut.count_r, 0);
    run(2);

    // 1: single read, base timing
    clear_logs();
    c0 = cyc;
    send_req(32'h0000_1234, 4'd2, REQ_READ);
    run(12);
    check("t1_mem_reads", mem_addr_q.size(), 1);
    check("t1_mem_addr", mem_addr_q.size() > 0 ? mem_addr_q[0] : 32'hFFFF_FFFF, 32'h0000_1220);
    check("t1_mem_cycle", mem_cyc_q.size() > 0 ? mem_cyc_q[0] - c0 : -1, 3);
    check("t1_sends", send_q.size(), 1);
    if (send_q.size() > 0) begin
      check("t1_send_cycle", send_cyc_q[0] - c0, 7);
      check("t1_send_addr", send_q[0].addr, 32'h0000_1220);
      check("t1_send_data", send_q[0].data, line_of(32'h0000_1220));
      check("t1_send_dst", send_q[0].dst, 4'd2);
      check("t1_send_src", send_q[0].src, 4'd15);
    end

    // 2: back-to-back reads
    clear_logs();
    c0 = cyc;
    for (int i = 1; i <= 4; i++) send_req(32'(i) << 8, 4'(i), REQ_READ);
    run(60);
    check("t2_busy_rise", busy_first - c0, 3);
    check("t2_sends", send_q.size(), 4);
    for (int i = 0; i < 4 && i < send_q.size(); i++) begin
      check("t2_order_addr", send_q[i].addr, 32'(i + 1) << 8);
      check("t2_order_data", send_q[i].data, line_of(32'(i + 1) << 8));
      check("t2_order_dst", send_q[i].dst, 4'(i + 1));
    end
    check("t2_no_overflow", dut.overflow_r, 1'b0);
    check("t2_busy_clear", req_bus_busy, 1'b0);

    // 3: grant withheld for five cycles
    clear_logs();
    gnt_delay = 5;
    c0 = cyc;
    send_req(32'h0000_2000, 4'd5, REQ_READ);
    run(20);
    gnt_delay = 0;
    check("t3_req_wait", nogrant_cycles, 5);
    check("t3_sends", send_q.size(), 1);
    check("t3_send_cycle", send_cyc_q.size() > 0 ? send_cyc_q[0] - c0 : -1, 12);
    check("t3_send_data", send_q.size() > 0 ? send_q[0].data : '0, line_of(32'h0000_2000));

    // 4: cache-to-cache response during the snoop window
    clear_logs();
    req_bus_msg = '{valid: 1'b1, addr: 32'h0000_0040, src: 4'd3, kind: REQ_READ};
    step();
    req_bus_msg = '0;
    resp_bus_msg = '0;
    resp_bus_msg.valid = 1'b1;
    resp_bus_msg.addr  = 32'h0000_0040;
    step();
    resp_bus_msg = '0;
    run(15);
`ifdef COH_MEM_SNOOP_CANCEL_EN
    check("t4_no_mem_read", mem_addr_q.size(), 0);
    check("t4_no_send", send_q.size(), 0);
`else
    check("t4_mem_reads", mem_addr_q.size(), 1);
    check("t4_send_data", send_q.size() > 0 ? send_q[0].data : '0, line_of(32'h0000_0040));
`endif
    check("t4_fifo_empty", dut.count_r, 0);
    check("t4_state_idle", 3'(dut.state_r), 3'd0);

    // 5: reset while the memory read is outstanding
    clear_logs();
    mem_lat = 20;
    for (int i = 5; i <= 7; i++) send_req(32'(i) << 8, 4'(i), REQ_READ);
    for (int i = 0; i < 10 && !mem_read; i++) step();
    check("t5_mem_read_up", mem_read, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_outputs_zero", {resp_bus_tx, resp_bus_req, resp_bus_busy, req_bus_busy, mem_addr, mem_read}, '0);
    check("t5_fifo_empty", dut.count_r, 0);
    mem_lat = 3;
    clear_logs();
    mem_resp  = 1'b1;
    mem_rdata = line_of(32'h0000_0500);
    step();
    run(15);
    check("t5_no_send", send_q.size(), 0);
    check("t5_no_mem_read", mem_addr_q.size(), 0);

    // 6: non-read traffic and a stray grant
    clear_logs();
    send_req(32'h0000_0800, 4'd1, REQ_WRITEBACK);
    check("t6_no_push", dut.count_r, 0);
    send_req(32'h0000_0900, 4'd2, REQ_UPGRADE);
    resp_bus_gnt = 1'b1;
    step();
    run(15);
    check("t6_no_mem_read", mem_addr_q.size(), 0);
    check("t6_no_send", send_q.size(), 0);

    check("tx_zero_outside_send", tx_leak, 0);
    check("mem_addr_stable", mem_unstable, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
